// File: rtl/kws_uart_infer_ctrl.sv
// -----------------------------------------------------------------------------
// kws_uart_infer_ctrl
//
// Bridges a byte-oriented UART link to a keyword-spotting accelerator that has
// AXI-Stream input and result ports.
//
// Operation:
//   - In IDLE, a 0xA5 sync byte on the rx side opens a frame. Every other byte
//     is discarded.
//   - In LOAD, the next N_IN_BYTES rx bytes are forwarded one at a time to the
//     accelerator input stream through a one-entry holding register.
//   - In WAIT_OUT, the block waits for the one-byte class result and counts
//     latency cycles, giving up after TIMEOUT_CYCLES.
//   - In SEND, a 6-byte response goes out on the tx side:
//       status, class, latency[7:0], latency[15:8], latency[23:16], latency[31:24]
//
// The UART receiver has no backpressure. A byte that arrives while the holding
// register is still occupied is dropped. It still counts toward the frame
// length, so the frame always closes after N_IN_BYTES rx bytes. The response
// then reports status 0xEF (overrun).
//
// Ports:
//   sys_clock     : single clock, rising edge
//   reset         : synchronous, active-high
//   rx_data/valid : received UART byte, one-cycle strobe, no backpressure
//   tx_data/valid/ready : response byte towards the UART transmitter
//   m_axis_*      : accelerator input stream (8-bit beats)
//   s_axis_*      : accelerator result stream (class index)
//   busy          : high whenever the FSM is not in IDLE
//   dbg_state     : current FSM state (0 IDLE, 1 LOAD, 2 WAIT_OUT, 3 SEND)
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising edge where valid and ready are both high. Once valid is raised
// it stays high, with data unchanged, until that transfer (reset excepted).
// -----------------------------------------------------------------------------
module kws_uart_infer_ctrl #(
  parameter int N_IN_BYTES     = 490,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Wide enough to hold the value N_IN_BYTES itself.
  localparam int CNT_W = $clog2(N_IN_BYTES + 1);
  localparam logic [CNT_W-1:0] N_LAST    = CNT_W'(N_IN_BYTES);
  localparam logic [31:0]      TIMEOUT_L = 32'(TIMEOUT_CYCLES);

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [7:0] ST_OK         = 8'h00;
  localparam logic [7:0] ST_OVERRUN    = 8'hEF;
  localparam logic [7:0] ST_TIMEOUT    = 8'hEE;
  localparam logic [7:0] CLASS_TIMEOUT = 8'hFF;
  localparam logic [2:0] LAST_TX_IDX   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD     = 2'd1,
    S_WAIT_OUT = 2'd2,
    S_SEND     = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Datapath registers
  logic             hold_full;
  logic [7:0]       hold_data;
  logic [CNT_W-1:0] in_count;
  logic [31:0]      latency;
  logic [7:0]       status;
  logic [7:0]       result_class;
  logic [2:0]       tx_idx;

  // Per-cycle events
  logic             sync_seen;
  logic             m_hs;
  logic             s_hs;
  logic             tx_hs;
  logic             rx_take;
  logic             rx_capture;
  logic             rx_drop;
  logic             full_next;
  logic [CNT_W-1:0] count_next;
  logic             load_done;
  logic             timeout_hit;

  always_comb begin
    sync_seen = (state == S_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    m_hs      = hold_full && m_axis_tready;
    s_hs      = (state == S_WAIT_OUT) && s_axis_tvalid;
    tx_hs     = (state == S_SEND) && tx_ready;

    // Bytes beyond the frame length are ignored. This only matters while the
    // last byte is still waiting in the holding register.
    rx_take    = (state == S_LOAD) && rx_valid && (in_count != N_LAST);
    // The register can take a new byte when it is empty, or when it empties
    // on this same edge.
    rx_capture = rx_take && (!hold_full || m_hs);
    rx_drop    = rx_take && hold_full && !m_hs;

    if (rx_capture) begin
      full_next = 1'b1;
    end else if (m_hs) begin
      full_next = 1'b0;
    end else begin
      full_next = hold_full;
    end

    count_next = rx_take ? (in_count + CNT_W'(1)) : in_count;

    // The frame is complete once every byte has been counted and the last
    // surviving byte has been handed to the accelerator.
    load_done   = (state == S_LOAD) && (count_next == N_LAST) && !full_next;

    // Only checked when no result handshake happens on the same edge. In
    // that case the result wins.
    timeout_hit = (state == S_WAIT_OUT) && (latency >= TIMEOUT_L);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (sync_seen) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_done) begin
          next_state = S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
        if (s_hs || timeout_hit) begin
          next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_hs && (tx_idx == LAST_TX_IDX)) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // tx_data is selected from registers that do not change during SEND. It
  // therefore stays stable while a byte is stalled. After reset every source
  // register is zero, so tx_data reads 0x00.
  always_comb begin
    busy          = (state != S_IDLE);
    s_axis_tready = (state == S_WAIT_OUT);
    tx_valid      = (state == S_SEND);
    case (tx_idx)
      3'd0:    tx_data = status;
      3'd1:    tx_data = result_class;
      3'd2:    tx_data = latency[7:0];
      3'd3:    tx_data = latency[15:8];
      3'd4:    tx_data = latency[23:16];
      default: tx_data = latency[31:24];
    endcase
  end

  assign m_axis_tdata  = hold_data;
  assign m_axis_tvalid = hold_full;
  assign dbg_state     = state;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      hold_full    <= 1'b0;
      hold_data    <= 8'h00;
      in_count     <= '0;
      latency      <= 32'd0;
      status       <= ST_OK;
      result_class <= 8'h00;
      tx_idx       <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sync_seen) begin
            in_count <= '0;
            latency  <= 32'd0;
            status   <= ST_OK;
          end
        end

        S_LOAD: begin
          hold_full <= full_next;
          in_count  <= count_next;
          if (rx_capture) begin
            hold_data <= rx_data;
          end
          if (rx_drop) begin
            status <= ST_OVERRUN;
          end
          if (load_done) begin
            latency <= 32'd0;
          end
        end

        S_WAIT_OUT: begin
          if (s_hs) begin
            // The latency counter freezes at its current value.
            result_class <= s_axis_tdata;
          end else if (timeout_hit) begin
            // A timeout replaces any overrun status.
            status       <= ST_TIMEOUT;
            result_class <= CLASS_TIMEOUT;
          end else if (latency != 32'hFFFF_FFFF) begin
            latency <= latency + 32'd1;
          end
        end

        S_SEND: begin
          if (tx_hs) begin
            tx_idx <= (tx_idx == LAST_TX_IDX) ? 3'd0 : (tx_idx + 3'd1);
          end
        end

        default: begin
          hold_full <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kws_uart_infer_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for kws_uart_infer_ctrl, built with N_IN_BYTES=4 and
// TIMEOUT_CYCLES=100.
//
// Structure:
//   - A table of complete frames is applied in a loop. Each entry holds the
//     junk byte sent in IDLE, the four data bytes, the result class, the
//     result delay and the expected response.
//   - Hand-written sequences cover input backpressure, tx stalls and reset in
//     the middle of a frame.
//   - Monitors at the falling edge compare every m_axis beat and every tx byte
//     against expected queues. They also check that stalled data is held.
//
// Timing: inputs change 1 ns after the rising edge. Outputs are sampled on the
// falling edge or 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_kws_uart_infer_ctrl;

  localparam int N_IN = 4;
  localparam int TMO  = 100;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  kws_uart_infer_ctrl #(
    .N_IN_BYTES     (N_IN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clock     (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];     // expected tx bytes
  logic [7:0] exp_m_q[$];   // expected m_axis beats
  bit         stall_en = 1'b0;
  int         stall_cnt = 0;

  typedef struct packed {
    logic [7:0]  pre;     // byte sent in IDLE before the sync byte
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [7:0]  cls;     // result class driven on s_axis
    int          delay;   // WAIT_OUT cycles before the result, -1 = never
    logic [1:0]  noise;   // 1: 0xA5 in WAIT_OUT, 2: also 0xA5 in SEND
    logic [7:0]  st;      // expected status byte
    logic [7:0]  cl;      // expected class byte
    logic [31:0] lat;     // expected latency
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [7:0] pre, b0, b1, b2, b3, cls,
                              input int delay, input logic [1:0] noise,
                              input logic [7:0] st, cl, input logic [31:0] lat);
    vec_t v;
    v.pre = pre; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3; v.cls = cls;
    v.delay = delay; v.noise = noise; v.st = st; v.cl = cl; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (each starts and ends 1 ns after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_resp(input logic [7:0] st, input logic [7:0] cl, input logic [31:0] lat);
    exp_q.push_back(st);
    exp_q.push_back(cl);
    exp_q.push_back(lat[7:0]);
    exp_q.push_back(lat[15:8]);
    exp_q.push_back(lat[23:16]);
    exp_q.push_back(lat[31:24]);
  endtask

  // Returns on the first WAIT_OUT cycle, while the latency counter is 0.
  task automatic wait_wait_out();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("enter_wait_out", 32'(ok), 32'd1);
  endtask

  task automatic do_result(input logic [7:0] cls, input int delay, input logic [1:0] noise);
    if (delay >= 0) begin
      for (int k = 0; k < delay; k++) begin
        if (noise != 2'd0 && k == 0) begin
          rx_data  = 8'hA5;
          rx_valid = 1'b1;
        end
        tick();
        rx_valid = 1'b0;
      end
      s_axis_tdata  = cls;
      s_axis_tvalid = 1'b1;
      tick();
      s_axis_tvalid = 1'b0;
      if (noise == 2'd2) begin
        send_rx(8'hA5);
      end
    end else if (noise != 2'd0) begin
      send_rx(8'hA5);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && !busy && !tx_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("resp_done", 32'(ok), 32'd1);
    check("m_beats_done", 32'(exp_m_q.size()), 32'd0);
  endtask

  task automatic run_frame(input vec_t v);
    exp_m_q.push_back(v.b0);
    exp_m_q.push_back(v.b1);
    exp_m_q.push_back(v.b2);
    exp_m_q.push_back(v.b3);
    push_resp(v.st, v.cl, v.lat);
    send_rx(v.pre);
    check("idle_discard_busy", 32'(busy), 32'd0);
    send_rx(8'hA5);
    check("sync_busy", 32'(busy), 32'd1);
    send_rx(v.b0);
    send_rx(v.b1);
    send_rx(v.b2);
    send_rx(v.b3);
    wait_wait_out();
    do_result(v.cls, v.delay, v.noise);
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_dbg_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // tx sink: always ready, or in stall mode low for 5 cycles per byte
  // ---------------------------------------------------------------------------
  initial begin
    tx_ready = 1'b1;
    forever begin
      tick();
      if (!stall_en) begin
        tx_ready = 1'b1;
      end else if (tx_ready) begin
        tx_ready  = 1'b0;
        stall_cnt = tx_valid ? 1 : 0;
      end else if (tx_valid) begin
        stall_cnt++;
        if (stall_cnt == 6) begin
          tx_ready = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  logic [7:0] tx_prev;
  logic [7:0] m_prev;
  bit         tx_hold = 1'b0;
  bit         m_hold  = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      tx_hold = 1'b0;
      m_hold  = 1'b0;
    end else begin
      if (tx_hold) begin
        check("tx_valid_held", 32'(tx_valid), 32'd1);
        check("tx_data_stable", 32'(tx_data), 32'(tx_prev));
      end
      if (m_hold) begin
        check("m_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        check("m_tdata_stable", 32'(m_axis_tdata), 32'(m_prev));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_extra: got byte 0x%0h, expected none", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_m_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL m_beat_extra: got beat 0x%0h, expected none", m_axis_tdata);
        end else begin
          check("m_beat", 32'(m_axis_tdata), 32'(exp_m_q.pop_front()));
        end
      end
      tx_hold = tx_valid && !tx_ready;
      tx_prev = tx_data;
      m_hold  = m_axis_tvalid && !m_axis_tready;
      m_prev  = m_axis_tdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset         = 1'b1;
    rx_data       = 8'h00;
    rx_valid      = 1'b0;
    m_axis_tready = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;

    //            pre    b0     b1     b2     b3     cls    dly  nz    st     cl     lat
    vecs[0] = mk(8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07,  10, 2'd0, 8'h00, 8'h07, 32'd10);
    vecs[1] = mk(8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h0B,   0, 2'd0, 8'h00, 8'h0B, 32'd0);
    vecs[2] = mk(8'h5A, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'hFE,  99, 2'd1, 8'h00, 8'hFE, 32'd99);
    vecs[3] = mk(8'hA4, 8'h10, 8'h20, 8'h30, 8'h40, 8'h02, 100, 2'd0, 8'h00, 8'h02, 32'd100);
    vecs[4] = mk(8'h12, 8'h55, 8'hAA, 8'h5A, 8'hA5, 8'h33,  -1, 2'd1, 8'hEE, 8'hFF, 32'd100);
    vecs[5] = mk(8'h00, 8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h09,  37, 2'd2, 8'h00, 8'h09, 32'd37);

    tick();
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Table-driven frames: nominal, edge latencies, tie and timeout.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
    end

    // Input backpressure: m_axis_tready stays low while all four data bytes
    // arrive. 0x01 occupies the register and the next three are dropped but
    // counted. Releasing ready lets 0x01 through and closes the frame at once.
    exp_m_q.push_back(8'h01);
    push_resp(8'hEF, 8'h03, 32'd5);
    m_axis_tready = 1'b0;
    send_rx(8'hA5);
    send_rx(8'h01);
    send_rx(8'h02);
    send_rx(8'h03);
    send_rx(8'h04);
    check("bp_still_load", 32'(s_axis_tready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("bp_tdata", 32'(m_axis_tdata), 32'h01);
    m_axis_tready = 1'b1;
    tick();
    check("bp_enter_wait", 32'(s_axis_tready), 32'd1);
    do_result(8'h03, 5, 2'd0);
    wait_idle();

    // tx stall: the same response order as the nominal frame. The status must
    // be cleared after the overrun frame above.
    stall_en = 1'b1;
    run_frame(mk(8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 10, 2'd2, 8'h00, 8'h07, 32'd10));
    stall_en = 1'b0;
    tick();

    // Reset mid-LOAD: 0x01 is delivered and 0x02 is left in the holding
    // register when reset hits.
    exp_m_q.push_back(8'h01);
    send_rx(8'hA5);
    send_rx(8'h01);
    tick();
    m_axis_tready = 1'b0;
    send_rx(8'h02);
    check("mid_hold_tdata", 32'(m_axis_tdata), 32'h02);
    reset = 1'b1;
    tick();
    tick();
    check_reset_outputs("mid_rst");
    check("mid_rst_beats", 32'(exp_m_q.size()), 32'd0);
    reset         = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    run_frame(mk(8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h21, 3, 2'd0, 8'h00, 8'h21, 32'd3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound in case the DUT never releases the bench.
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish after 500000 ns, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
